// File: rtl/digit_rx_pkg.sv
// Shared definitions for the digit frame receiver: frame length, counter
// widths and the receive FSM states. DIGIT_RX_PARITY_EN adds a ninth,
// odd-parity bit to every frame.
package digit_rx_pkg;

`ifdef DIGIT_RX_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/digit_rx_shifter.sv
// Serial shift register plus bit counter. o_frame is the frame as it will
// look once the current serial bit is sampled, so the controller can grab
// a complete frame on the same edge that samples its last bit.
module digit_rx_shifter
    import digit_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,   // start a new frame with i_bit as bit 0
    input  logic                  i_shift,  // append i_bit to the frame in progress
    input  logic                  i_clear,  // i_bit is the last bit: rewind the counter
    input  logic                  i_bit,
    output logic [CNT_W-1:0]      o_cnt,
    output logic [FRAME_BITS-1:0] o_frame
);

    logic [FRAME_BITS-2:0] r_sr;
    logic [CNT_W-1:0]      r_cnt;

    assign o_frame = {r_sr, i_bit};
    assign o_cnt   = r_cnt;

    // Shift MSB first: the first bit received ends up in the top of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= {{(FRAME_BITS-2){1'b0}}, i_bit};
            r_cnt <= CNT_W'(1);
        end else if (i_shift) begin
            r_sr  <= o_frame[FRAME_BITS-2:0];
            r_cnt <= i_clear ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_frame_receiver.sv
// Receives serial 7-segment digit frames, commits each complete frame to a
// rolling set of digit slots and exposes the last frame plus a read port.
// Build option: DIGIT_RX_PARITY_EN (9-bit frames with odd parity check).
module digit_frame_receiver
    import digit_rx_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             frame_sync,
    input  logic             serial_in,
    input  logic [2:0]       rd_select,
    output logic [6:0]       led_out,
    output logic             dp_out,
    output logic [IDX_W-1:0] digit_index,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [7:0]       rd_led
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W:0]   ND       = (IDX_W + 1)'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    rx_state_e             r_state, w_next;
    logic                  w_load, w_shift, w_last, w_abort;
    logic [CNT_W-1:0]      w_cnt;
    logic [FRAME_BITS-1:0] w_frame;
    logic [7:0]            w_data;
    logic                  w_par_ok;

    // A finished frame waits here one cycle before it is committed.
    logic                  r_pend_ok, r_pend_err;
    logic [7:0]            r_pend_data;
    logic [7:0]            r_slots [NUM_DIGITS];

`ifdef DIGIT_RX_PARITY_EN
    assign w_data   = w_frame[8:1];
    assign w_par_ok = ^w_frame;   // data plus parity must hold an odd count of ones
`else
    assign w_data   = w_frame;
    assign w_par_ok = 1'b1;
`endif

    digit_rx_shifter u_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_clear (w_last),
        .i_bit   (serial_in),
        .o_cnt   (w_cnt),
        .o_frame (w_frame)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state and shifter control; nothing moves while en is low.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_last  = 1'b0;
        w_abort = 1'b0;
        if (en) begin
            unique case (r_state)
                IDLE: begin
                    if (frame_sync) begin
                        w_load = 1'b1;
                        w_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (frame_sync) begin
                        // Resync mid-frame: drop what we have, this bit starts a new frame.
                        w_abort = 1'b1;
                        w_load  = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                        if (w_cnt == LAST_CNT) begin
                            w_last = 1'b1;
                            w_next = IDLE;
                        end
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Commit pipeline: capture the frame on its last bit, publish it one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_out     <= '0;
            dp_out      <= 1'b0;
            digit_index <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            r_pend_ok   <= 1'b0;
            r_pend_err  <= 1'b0;
            r_pend_data <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) r_slots[i] <= '0;
        end else if (en) begin
            frame_valid <= r_pend_ok;
            frame_err   <= r_pend_err | w_abort;
            r_pend_ok   <= w_last & w_par_ok;
            r_pend_err  <= w_last & ~w_par_ok;
            if (w_last) r_pend_data <= w_data;
            if (r_pend_ok) begin
                dp_out               <= r_pend_data[7];
                led_out              <= r_pend_data[6:0];
                r_slots[digit_index] <= r_pend_data;
                digit_index          <= (digit_index == LAST_IDX) ? '0 : digit_index + 1'b1;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end
    end

    // Registered slot read; unpopulated slot numbers read as blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   rd_led <= '0;
        else if (en) rd_led <= ({1'b0, rd_select} < ND) ? r_slots[rd_select] : 8'h00;
    end

endmodule

// File: tb/tb_digit_frame_receiver.sv
// Directed bench for digit_frame_receiver (6 digit slots).
module tb_digit_frame_receiver;
    import digit_rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset, en, frame_sync, serial_in;
    logic [2:0] rd_select;
    logic [6:0] led_out;
    logic       dp_out;
    logic [2:0] digit_index;
    logic       frame_valid, frame_err;
    logic [7:0] rd_led;

    int n_chk  = 0;
    int n_fail = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    logic [2:0] idx_q[$];

    digit_frame_receiver #(.NUM_DIGITS(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .frame_sync  (frame_sync),
        .serial_in   (serial_in),
        .rd_select   (rd_select),
        .led_out     (led_out),
        .dp_out      (dp_out),
        .digit_index (digit_index),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .rd_led      (rd_led)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            idx_q.push_back(digit_index);
        end
        if (frame_err) fe_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic s, input logic b);
        frame_sync = s;
        serial_in  = b;
        tick();
        frame_sync = 1'b0;
    endtask

    // Bit i of the on-wire frame for data byte v (MSB first, then odd parity).
    function automatic logic fbit(input logic [7:0] v, input int i);
        if (i < 8) return v[7-i];
        return ~^v;
    endfunction

    task automatic send_frame(input logic [7:0] v);
        for (int i = 0; i < FRAME_BITS; i++) send_bit(i == 0, fbit(v, i));
    endtask

    task automatic do_reset;
        reset = 1'b1; en = 1'b1; frame_sync = 1'b0; serial_in = 1'b0; rd_select = 3'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; frame_sync = 1'b0; serial_in = 1'b1; rd_select = 3'd0;
        tick();
        n_chk++;
        if ({led_out, dp_out, digit_index, frame_valid, frame_err, rd_led} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {led_out, dp_out, digit_index, frame_valid, frame_err, rd_led});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame;
        int c0;
        do_reset();
        c0 = fv_cnt;
        send_frame(8'h7E);
        n_chk++;
        if (frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_latency: frame_valid got %b want 0", frame_valid);
        end
        tick();
        n_chk++;
        if ({frame_valid, led_out, dp_out, digit_index} !== {1'b1, 7'h7E, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL single_commit: got fv=%b led=%h dp=%b idx=%0d want fv=1 led=7e dp=0 idx=1",
                     frame_valid, led_out, dp_out, digit_index);
        end
        tick();
        n_chk++;
        if (frame_valid !== 1'b0 || fv_cnt - c0 != 1) begin
            n_fail++;
            $display("FAIL single_pulse: fv=%b pulses=%0d want fv=0 pulses=1", frame_valid, fv_cnt - c0);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        logic [2:0] exp_idx [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        logic [2:0] sel     [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
        logic [7:0] exp_rd  [4] = '{8'h07, 8'h06, 8'h00, 8'h00};
        do_reset();
        idx_q.delete();
        c0 = fv_cnt;
        for (int v = 1; v <= 7; v++) send_frame(8'(v));
        tick();
        tick();
        n_chk++;
        if (fv_cnt - c0 != 7 || idx_q.size() != 7) begin
            n_fail++;
            $display("FAIL b2b_count: pulses=%0d idx_entries=%0d want 7", fv_cnt - c0, idx_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_chk++;
                if (idx_q[i] !== exp_idx[i]) begin
                    n_fail++;
                    $display("FAIL b2b_index[%0d]: got %0d want %0d", i, idx_q[i], exp_idx[i]);
                end
            end
        end
        n_chk++;
        if ({led_out, dp_out} !== {7'h07, 1'b0}) begin
            n_fail++; $display("FAIL b2b_last: led=%h dp=%b want 07/0", led_out, dp_out);
        end
        for (int k = 0; k < 4; k++) begin
            rd_select = sel[k];
            tick();
            n_chk++;
            if (rd_led !== exp_rd[k]) begin
                n_fail++; $display("FAIL b2b_read[%0d]: got %h want %h", sel[k], rd_led, exp_rd[k]);
            end
        end
        rd_select = 3'd0;
    endtask

    task automatic test_abort;
        do_reset();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, fbit(8'h5A, 0));
        n_chk++;
        if ({frame_err, frame_valid, digit_index} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL abort_err: err=%b fv=%b idx=%0d want err=1 fv=0 idx=0",
                     frame_err, frame_valid, digit_index);
        end
        for (int i = 1; i < FRAME_BITS; i++) send_bit(1'b0, fbit(8'h5A, i));
        n_chk++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL abort_err_pulse: err=%b want 0", frame_err);
        end
        tick();
        n_chk++;
        if ({frame_valid, led_out, dp_out, digit_index} !== {1'b1, 7'h5A, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL abort_recover: fv=%b led=%h dp=%b idx=%0d want 1/5a/0/1",
                     frame_valid, led_out, dp_out, digit_index);
        end
    endtask

    task automatic test_enable;
        do_reset();
        for (int i = 0; i < 3; i++) send_bit(i == 0, fbit(8'hA5, i));
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            serial_in  = k[0];
            frame_sync = (k == 2);
            tick();
            n_chk++;
            if ({frame_valid, frame_err, digit_index} !== 5'b0) begin
                n_fail++;
                $display("FAIL enable_hold[%0d]: fv=%b err=%b idx=%0d want 0/0/0",
                         k, frame_valid, frame_err, digit_index);
            end
        end
        frame_sync = 1'b0;
        en = 1'b1;
        for (int i = 3; i < FRAME_BITS; i++) send_bit(1'b0, fbit(8'hA5, i));
        tick();
        n_chk++;
        if ({frame_valid, led_out, dp_out, digit_index} !== {1'b1, 7'h25, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL enable_resume: fv=%b led=%h dp=%b idx=%0d want 1/25/1/1",
                     frame_valid, led_out, dp_out, digit_index);
        end
    endtask

    task automatic test_reset_mid_frame;
        int e0;
        do_reset();
        send_frame(8'h81);
        tick();
        e0 = fe_cnt;
        for (int i = 0; i < 3; i++) send_bit(i == 0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({led_out, dp_out, digit_index, frame_valid, frame_err, rd_led} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0",
                     {led_out, dp_out, digit_index, frame_valid, frame_err, rd_led});
        end
        tick();
        reset = 1'b0;
        send_frame(8'h3C);
        tick();
        n_chk++;
        if ({frame_valid, led_out, dp_out, digit_index} !== {1'b1, 7'h3C, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL reset_next_frame: fv=%b led=%h dp=%b idx=%0d want 1/3c/0/1",
                     frame_valid, led_out, dp_out, digit_index);
        end
        rd_select = 3'd0;
        tick();
        n_chk++;
        if (rd_led !== 8'h3C || fe_cnt != e0) begin
            n_fail++;
            $display("FAIL reset_slot0: rd_led=%h errs=%0d want 3c errs=0", rd_led, fe_cnt - e0);
        end
    endtask

`ifdef DIGIT_RX_PARITY_EN
    task automatic test_parity;
        do_reset();
        for (int i = 0; i < 8; i++) send_bit(i == 0, fbit(8'h7E, i));
        send_bit(1'b0, 1'b0);
        tick();
        n_chk++;
        if ({frame_err, frame_valid, digit_index, led_out} !== {1'b1, 1'b0, 3'd0, 7'h00}) begin
            n_fail++;
            $display("FAIL parity_bad: err=%b fv=%b idx=%0d led=%h want 1/0/0/00",
                     frame_err, frame_valid, digit_index, led_out);
        end
        send_frame(8'h7E);
        tick();
        n_chk++;
        if ({frame_valid, frame_err, digit_index, led_out} !== {1'b1, 1'b0, 3'd1, 7'h7E}) begin
            n_fail++;
            $display("FAIL parity_good: fv=%b err=%b idx=%0d led=%h want 1/0/1/7e",
                     frame_valid, frame_err, digit_index, led_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_abort();
        test_enable();
        test_reset_mid_frame();
`ifdef DIGIT_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
